// File: rtl/alu_issue_pkg.sv
// Shared opcode encodings, flag bit positions and legal-opcode check for the ALU issue stage.
package alu_issue_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLT = 4'b0111;

    // Bit positions inside the 3-bit response flag field {overflow, cout, zero}.
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_COUT = 1;
    localparam int FLAG_OVF  = 2;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLT: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is read until a push has written it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/response stage around the 32-bit ALU: command FIFO, two-stage tracking pipe, credited response FIFO.
// Optional feature: define ALU_ISSUE_ILLEGAL_CHK_EN to squash illegal opcodes into error responses.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);

    localparam int CMD_W = 68 + TAG_W;
    localparam int RSP_W = 36 + TAG_W;
    localparam int CC_W  = $clog2(CMD_DEPTH) + 1;
    localparam int RC_W  = $clog2(RSP_DEPTH) + 1;

    logic [CMD_W-1:0] cmd_head;
    logic             cmd_empty;
    logic [CC_W-1:0]  cmd_count;
    logic [3:0]       head_op;
    logic [31:0]      head_a;
    logic [31:0]      head_b;
    logic [TAG_W-1:0] head_tag;
    logic             head_err;
    logic             cmd_push;
    logic             issue;

    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_err;
    logic             s2_valid;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_err;

    logic [RSP_W-1:0] rsp_in;
    logic [RSP_W-1:0] rsp_head;
    logic             rsp_empty;
    logic [RC_W-1:0]  rsp_count;
    logic             rsp_pop;
    logic [RC_W:0]    used;
    logic [2:0]       alu_flags;

    logic             h_err;
    logic [TAG_W-1:0] h_tag;
    logic [2:0]       h_flags;
    logic [31:0]      h_result;

    // ---------------- command side ----------------
    assign cmd_ready = (cmd_count != CC_W'(CMD_DEPTH));
    assign cmd_push  = cmd_valid && cmd_ready;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_push),
        .push_data ({cmd_op, cmd_a, cmd_b, cmd_tag}),
        .pop       (issue),
        .pop_data  (cmd_head),
        .empty     (cmd_empty),
        .count     (cmd_count)
    );

    assign {head_op, head_a, head_b, head_tag} = cmd_head;

`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
    assign head_err = !is_legal_op(head_op);
`else
    assign head_err = 1'b0;
`endif

    // Credits: every in-flight op owns a response slot; a slot popped this cycle is already free.
    assign rsp_pop = rsp_valid && rsp_ready;
    assign used    = {1'b0, rsp_count} + (RC_W+1)'(s1_valid) + (RC_W+1)'(s2_valid)
                   - (RC_W+1)'(rsp_pop);
    assign issue   = !cmd_empty && (used < (RC_W+1)'(RSP_DEPTH));

    // ---------------- issue / tracking pipe ----------------
    // Stage 1 mirrors the operands on the ALU inputs; stage 2 marks the cycle the ALU holds them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_src1 <= '0;
            alu_src2 <= '0;
            alu_ctrl <= OP_AND;
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_err   <= 1'b0;
            s2_valid <= 1'b0;
            s2_tag   <= '0;
            s2_err   <= 1'b0;
        end else begin
            if (issue) begin
                alu_src1 <= head_a;
                alu_src2 <= head_b;
                alu_ctrl <= head_err ? OP_AND : head_op;
                s1_tag   <= head_tag;
                s1_err   <= head_err;
            end
            s1_valid <= issue;
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_err   <= s1_err;
        end
    end

    // ---------------- response side ----------------
    always_comb begin
        alu_flags            = '0;
        alu_flags[FLAG_ZERO] = alu_zero;
        alu_flags[FLAG_COUT] = alu_cout;
        alu_flags[FLAG_OVF]  = alu_overflow;
        if (s2_err) rsp_in = {1'b1, s2_tag, 3'b000, 32'h0};
        else        rsp_in = {1'b0, s2_tag, alu_flags, alu_result};
    end

    sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s2_valid),
        .push_data (rsp_in),
        .pop       (rsp_pop),
        .pop_data  (rsp_head),
        .empty     (rsp_empty),
        .count     (rsp_count)
    );

    assign {h_err, h_tag, h_flags, h_result} = rsp_head;

    // Payload is forced to zero while empty so stale or unwritten storage never shows.
    assign rsp_valid  = !rsp_empty;
    assign rsp_result = rsp_valid ? h_result : '0;
    assign rsp_flags  = rsp_valid ? h_flags  : '0;
    assign rsp_tag    = rsp_valid ? h_tag    : '0;
    assign rsp_err    = rsp_valid ? h_err    : 1'b0;

    assign busy = !cmd_empty || s1_valid || s2_valid || !rsp_empty;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised scoreboard bench for alu_issue_stage with a behavioural ALU attached to its ALU ports.
module tb_alu_issue_stage;

    localparam int CMD_DEPTH = 4;
    localparam int RSP_DEPTH = 4;
    localparam int TAG_W     = 4;
    localparam int EW        = 36 + TAG_W;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      alu_src1;
    logic [31:0]      alu_src2;
    logic [3:0]       alu_ctrl;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             alu_cout;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [2:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int n_rsp  = 0;
    int cyc    = 0;

    logic [EW-1:0]    exp_q[$];
    logic [TAG_W-1:0] log_tag[$];
    logic             log_err[$];
    logic [31:0]      log_res[$];
    int               log_cyc[$];

    logic [3:0]  legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
    logic [31:0] corner    [4] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_stage #(
        .CMD_DEPTH (CMD_DEPTH),
        .RSP_DEPTH (RSP_DEPTH),
        .TAG_W     (TAG_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_tag      (rsp_tag),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    // Arithmetic definition of the ALU: returns {overflow, cout, zero, result}.
    function automatic logic [34:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        r = '0; c = 1'b0; v = 1'b0; s = '0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0110: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b1100: r = ~(a | b);
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {v, c, (r == 32'h0), r};
    endfunction

    // Behavioural ALU: one internal operand register, combinational result behind it.
    logic [31:0] alu_r1;
    logic [31:0] alu_r2;
    logic [3:0]  alu_rc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_r1 <= '0; alu_r2 <= '0; alu_rc <= '0;
        end else begin
            alu_r1 <= alu_src1; alu_r2 <= alu_src2; alu_rc <= alu_ctrl;
        end
    end
    assign {alu_overflow, alu_cout, alu_zero, alu_result} = alu_ref(alu_rc, alu_r1, alu_r2);

    // Expected response {err, tag, flags, result} for an accepted command.
    function automatic logic [EW-1:0] exp_of(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [TAG_W-1:0] tag);
        logic legal;
        legal = op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
        if (!legal) return {1'b1, tag, 35'h0};
`else
        if (!legal) return {1'b0, tag, alu_ref(op, a, b)};
`endif
        return {1'b0, tag, alu_ref(op, a, b)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            exp_q.push_back(exp_of(cmd_op, cmd_a, cmd_b, cmd_tag));
            n_acc++;
        end
    end

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp act=%0h exp=none", {rsp_err, rsp_tag, rsp_flags, rsp_result});
            end else begin
                e = exp_q.pop_front();
                check("rsp", 64'({rsp_err, rsp_tag, rsp_flags, rsp_result}), 64'(e));
            end
            log_tag.push_back(rsp_tag);
            log_err.push_back(rsp_err);
            log_res.push_back(rsp_result);
            log_cyc.push_back(cyc);
            n_rsp++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
        int   guard;
        logic acc;
        guard = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        do begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 300);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout act=stalled exp=accepted tag=%0d", tag);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy) && g < 1000) begin cycles(1); g++; end
        check(name, 64'(exp_q.size() == 0 && !busy), 64'd1);
    endtask

    task automatic clear_log();
        log_tag.delete(); log_err.delete(); log_res.delete(); log_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({pfx, "_alu_src1"},  64'(alu_src1), 64'd0);
        check({pfx, "_alu_src2"},  64'(alu_src2), 64'd0);
        check({pfx, "_alu_ctrl"},  64'(alu_ctrl), 64'd0);
        check({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({pfx, "_rsp_result"},64'(rsp_result), 64'd0);
        check({pfx, "_rsp_flags"}, 64'(rsp_flags), 64'd0);
        check({pfx, "_rsp_tag"},   64'(rsp_tag), 64'd0);
        check({pfx, "_rsp_err"},   64'(rsp_err), 64'd0);
        check({pfx, "_busy"},      64'(busy), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    bit rand_done;
    bit bp_done;

    initial begin
        int lat;
        int acc0;
        int rsp0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
        rsp_ready = 1'b0; rand_done = 1'b0; bp_done = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        // Latency on an idle pipe: ADD overflow corner.
        rsp_ready = 1'b1;
        send(4'b0010, 32'h7FFF_FFFF, 32'h1, 4'd3);
        cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 20);
        check("latency", 64'(lat), 64'd3);
        check("add_result", 64'(rsp_result), 64'h8000_0000);
        check("add_tag", 64'(rsp_tag), 64'd3);
        check("add_flags", 64'(rsp_flags), 64'b100);
        @(posedge clk); #1;
        wait_drain("drain_add");

        // SUB equal operands and SLT.
        clear_log();
        send(4'b0110, 32'd5, 32'd5, 4'd1);
        send(4'b0111, 32'd2, 32'd7, 4'd2);
        cmd_valid = 1'b0;
        wait_drain("drain_sub_slt");
        check("sub_slt_count", 64'(log_res.size()), 64'd2);
        if (log_res.size() == 2) begin
            check("sub_result", 64'(log_res[0]), 64'd0);
            check("slt_result", 64'(log_res[1]), 64'd1);
        end

        // Back-to-back 8 with free-running consumer.
        clear_log();
        for (int i = 0; i < 8; i++)
            send(legal_ops[$urandom_range(0, 5)], rand_operand(), rand_operand(), TAG_W'(i));
        cmd_valid = 1'b0;
        wait_drain("drain_b2b");
        check("b2b_count", 64'(log_tag.size()), 64'd8);
        if (log_tag.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("b2b_tag", 64'(log_tag[i]), 64'(i));
                check("b2b_cycle", 64'(log_cyc[i] - log_cyc[0]), 64'(i));
            end
        end

        // Backpressure: consumer stalled, 10 commands streamed.
        clear_log();
        rsp_ready = 1'b0;
        acc0 = n_acc; rsp0 = n_rsp;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(legal_ops[$urandom_range(0, 5)], rand_operand(), rand_operand(), TAG_W'(i));
                cmd_valid = 1'b0;
                bp_done = 1'b1;
            end
        join_none
        cycles(20);
        check("bp_accepted", 64'(n_acc - acc0), 64'(CMD_DEPTH + RSP_DEPTH));
        check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_no_pop", 64'(n_rsp - rsp0), 64'd0);
        rsp_ready = 1'b1;
        for (int g = 0; g < 400 && !bp_done; g++) cycles(1);
        check("bp_sender_done", 64'(bp_done), 64'd1);
        wait_drain("drain_bp");
        check("bp_count", 64'(log_tag.size()), 64'd10);
        if (log_tag.size() == 10)
            for (int i = 0; i < 10; i++) check("bp_tag", 64'(log_tag[i]), 64'(i));

        // Illegal opcode between legal neighbours.
        clear_log();
        send(4'b0010, 32'd10, 32'd20, 4'd1);
        send(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 4'd2);
        send(4'b0001, 32'hF0, 32'h0F, 4'd3);
        cmd_valid = 1'b0;
        wait_drain("drain_illegal");
        check("illegal_count", 64'(log_err.size()), 64'd3);
        if (log_err.size() == 3) begin
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
            check("illegal_err", 64'(log_err[1]), 64'd1);
`else
            check("illegal_err", 64'(log_err[1]), 64'd0);
`endif
            check("illegal_result", 64'(log_res[1]), 64'd0);
            check("neighbour_add", 64'(log_res[0]), 64'd30);
            check("neighbour_or", 64'(log_res[2]), 64'hFF);
        end

        // Randomised traffic with a randomly stalling consumer.
        fork
            begin
                while (!rand_done) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    cycles(1);
                end
            end
        join_none
        for (int i = 0; i < 150; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 5)];
            send(op, rand_operand(), rand_operand(), TAG_W'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b0;
                cycles($urandom_range(1, 3));
            end
        end
        cmd_valid = 1'b0;
        rand_done = 1'b1;
        cycles(1);
        rsp_ready = 1'b1;
        wait_drain("drain_random");

        // Asynchronous reset with work queued and in flight.
        rsp_ready = 1'b0;
        send(4'b0010, 32'd1, 32'd2, 4'd1);
        send(4'b0010, 32'd3, 32'd4, 4'd2);
        cmd_valid = 1'b0;
        cycles(6);
        for (int i = 0; i < 5; i++) send(4'b0001, rand_operand(), rand_operand(), TAG_W'(i + 8));
        #2;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("midreset");
        cycles(2);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        rsp0 = n_rsp;
        cycles(10);
        check("no_stale_rsp", 64'(n_rsp - rsp0), 64'd0);
        check("post_reset_busy", 64'(busy), 64'd0);

        // Pipe still works after reset.
        send(4'b1100, 32'h0, 32'h0, 4'd5);
        cmd_valid = 1'b0;
        wait_drain("drain_post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
